// File: rtl/pcm_interp_os.sv
// Linear 2**OSR_LOG2 interpolator feeding the delta/sigma DAC with a 20-bit PCM word and clock enable.
// Optional attenuation ramp on mute is enabled by defining PCM_MUTE_RAMP_EN.
module pcm_interp_os #(
  parameter int unsigned DIV      = 16,
  parameter int unsigned OSR_LOG2 = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] snd_in,
  input  logic        snd_valid,
  output logic        snd_ready,
  input  logic        mute,
  output logic        dac_ena,
  output logic [19:0] pcm_out,
  output logic        underrun
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned AW = 16 + OSR_LOG2 + 1;
  localparam logic [DW-1:0] DivLast = DW'(DIV - 1);
  localparam logic [OSR_LOG2-1:0] PhaseLast = '1;

  logic [DW-1:0]        div_cnt_q;
  logic                 active_q;
  logic [15:0]          fifo_q [2];
  logic                 wr_ptr_q;
  logic                 rd_ptr_q;
  logic [1:0]           count_q;
  logic [OSR_LOG2-1:0]  phase_q;
  logic signed [15:0]   cur_q;
  logic signed [16:0]   delta_q;
  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] acc_d;
  logic signed [AW-1:0] cur_ext;
  logic signed [AW-1:0] delta_ext;
  logic signed [19:0]   scaled;
  logic [19:0]          pcm_q;
  logic [19:0]          pcm_next;
  logic                 underrun_q;
  logic                 push;
  logic                 pop;
  logic                 boundary;
  logic [15:0]          head;

  // active_q keeps the strobe and ready low until the first clock after reset release.
  assign dac_ena   = active_q & (div_cnt_q == DivLast);
  assign snd_ready = active_q & (count_q != 2'd2);
  assign push      = snd_valid & snd_ready;
  assign boundary  = dac_ena & (phase_q == PhaseLast);
  assign pop       = boundary & (count_q != 2'd0);
  assign head      = fifo_q[rd_ptr_q];
  assign pcm_out   = pcm_q;
  assign underrun  = underrun_q;

  assign cur_ext   = {{(AW - 16){cur_q[15]}}, cur_q};
  assign delta_ext = {{(AW - 17){delta_q[16]}}, delta_q};

  always_comb begin
    acc_d = acc_q;
    if (boundary) begin
      acc_d = cur_ext <<< OSR_LOG2;
    end else if (dac_ena) begin
      acc_d = acc_q + delta_ext;
    end
  end

  assign scaled = 20'(acc_d >>> (OSR_LOG2 - 4));

`ifdef PCM_MUTE_RAMP_EN
  logic [3:0] att_q;
  logic [3:0] att_d;

  always_comb begin
    att_d = att_q;
    if (boundary) begin
      if (mute && (att_q != 4'd15)) begin
        att_d = att_q + 4'd1;
      end else if (!mute && (att_q != 4'd0)) begin
        att_d = att_q - 4'd1;
      end
    end
    pcm_next = (att_d == 4'd15) ? '0 : scaled >>> att_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      att_q <= '0;
    end else if (boundary) begin
      att_q <= att_d;
    end
  end
`else
  always_comb begin
    pcm_next = mute ? '0 : scaled;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q  <= '0;
      active_q   <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
      phase_q    <= '0;
      cur_q      <= '0;
      delta_q    <= '0;
      acc_q      <= '0;
      pcm_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      active_q  <= 1'b1;
      div_cnt_q <= (div_cnt_q == DivLast) ? '0 : div_cnt_q + 1'b1;

      if (push) begin
        fifo_q[wr_ptr_q] <= snd_in;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase

      underrun_q <= boundary & (count_q == 2'd0);

      if (dac_ena) begin
        phase_q <= phase_q + 1'b1;
        acc_q   <= acc_d;
        pcm_q   <= pcm_next;
      end

      // Empty buffer at a boundary holds the current sample flat.
      if (boundary) begin
        if (count_q != 2'd0) begin
          delta_q <= {head[15], head} - {cur_q[15], cur_q};
          cur_q   <= head;
        end else begin
          delta_q <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pcm_interp_os.sv
// Self-checking bench for pcm_interp_os: main instance DIV=4/OSR_LOG2=4 plus full-scale
// ramp instances for OSR_LOG2 4..8 at DIV=1.
module tb_pcm_interp_os;

  localparam int DIV = 4;
  localparam int OSR = 4;
  localparam int NPH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] snd_in = '0;
  logic        snd_valid = 1'b0;
  logic        mute = 1'b0;
  logic        snd_ready;
  logic        dac_ena;
  logic [19:0] pcm_out;
  logic        underrun;

  int total = 0;
  int bad = 0;
  int cyc, ena_cnt, k, seg_start, seg_end, mdl_pcm;
  int sb_q[$];
  int feed_mode = 0;
  int und_seen = 0;
  bit ena_seen;

  typedef struct {
    bit          mute;
    logic [19:0] pcm;
  } vec_t;
  vec_t tbl[21];

  always #5 clk = ~clk;

  pcm_interp_os #(.DIV(DIV), .OSR_LOG2(OSR)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .snd_in   (snd_in),
    .snd_valid(snd_valid),
    .snd_ready(snd_ready),
    .mute     (mute),
    .dac_ena  (dac_ena),
    .pcm_out  (pcm_out),
    .underrun (underrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    cyc = 0; ena_cnt = 0; k = 0; seg_start = 0; seg_end = 0; mdl_pcm = 0;
    sb_q.delete();
  endtask

  // One clock: scoreboard accepted samples, model the expected output, compare.
  task automatic tick();
    bit en, psh, m, exp_und;
    logic [15:0] d;
    en = dac_ena; psh = snd_valid && snd_ready; m = mute; d = snd_in;
    @(posedge clk); #1;
    cyc++;
    exp_und = 1'b0;
    if (en) begin
      ena_cnt++;
      if (ena_cnt % NPH == 0) begin
        seg_start = seg_end;
        if (sb_q.size() > 0) seg_end = sb_q.pop_front();
        else exp_und = 1'b1;
        k = 0;
      end else begin
        k++;
      end
      mdl_pcm = m ? 0 : seg_start * 16 + k * (seg_end - seg_start);
    end
    if (psh) begin
      sb_q.push_back(int'($signed(d)));
      case (feed_mode)
        1: snd_in = 16'h1000;
        2: snd_valid = 1'b0;
        3: snd_in = snd_in + 16'h0321;
        default: ;
      endcase
    end
    chk("underrun", underrun, exp_und);
    chk("pcm_out", pcm_out, mdl_pcm[19:0]);
    chk("dac_ena", dac_ena, (cyc % DIV) == DIV - 1);
    ena_seen = en;
    if (underrun) und_seen++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; #1;
    chk("rst_pcm", pcm_out, 0);
    chk("rst_ena", dac_ena, 0);
    chk("rst_und", underrun, 0);
    chk("rst_rdy", snd_ready, 0);
    snd_valid = 1'b0; mute = 1'b0; snd_in = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    mdl_reset();
    #1;
    chk("rdy_at_release", snd_ready, 0);
    tick();
    chk("rdy_after_release", snd_ready, 1);
  endtask

  task automatic run_until_ena(input int target, input int budget, input string name);
    int n = 0;
    while (ena_cnt < target && n < budget) begin
      tick();
      n++;
    end
    if (ena_cnt < target) chk({name, "_timeout"}, ena_cnt, target);
  endtask

  task automatic wait_ena();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!ena_seen && n < 16);
    if (!ena_seen) chk("ena_timeout", 0, 1);
  endtask

  // Full-scale 0x8000 -> 0x7FFF ramp for every OSR_LOG2, checked against a closed form.
  for (genvar g = 0; g < 5; g++) begin : g_fs
    localparam int O = 4 + g;
    localparam int N = 1 << O;
    logic [15:0] din = 16'h8000;
    logic        rdy, ena, und;
    logic [19:0] pcm;
    bit          done = 1'b0;

    pcm_interp_os #(.DIV(1), .OSR_LOG2(O)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .snd_in   (din),
      .snd_valid(1'b1),
      .snd_ready(rdy),
      .mute     (1'b0),
      .dac_ena  (ena),
      .pcm_out  (pcm),
      .underrun (und)
    );

    initial begin : mon
      int n, acc_n, prev, expv;
      bit rp, ep;
      n = 0; acc_n = 0; prev = 0; rp = 1'b0; ep = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          n = 0; acc_n = 0; rp = 1'b0; ep = 1'b0; din = 16'h8000;
        end else begin
          if (rp) acc_n++;
          din = (acc_n > 0) ? 16'h7FFF : 16'h8000;
          if (ep) begin
            n++;
            if (n >= 2 * N && n <= 3 * N) begin
              expv = (-32768 * N + (n - 2 * N) * 65535) >>> (O - 4);
              chk("fs_pcm", pcm, expv[19:0]);
              chk("fs_und", und, 0);
              if (n > 2 * N) chk("fs_mono", $signed(pcm) >= prev, 1);
              prev = $signed(pcm);
              if (n == 3 * N) done = 1'b1;
            end
          end
          rp = rdy;
          ep = ena;
        end
      end
    end
  end

  logic fs_all;
  assign fs_all = g_fs[0].done & g_fs[1].done & g_fs[2].done & g_fs[3].done & g_fs[4].done;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, n;
    for (int i = 0; i <= 16; i++) tbl[i] = '{mute: 1'b0, pcm: 20'(i * 32'h1000)};
    tbl[17] = '{mute: 1'b1, pcm: 20'h00000};
    tbl[18] = '{mute: 1'b1, pcm: 20'h00000};
    tbl[19] = '{mute: 1'b0, pcm: 20'h10000};
    tbl[20] = '{mute: 1'b0, pcm: 20'h10000};

    #2;
    do_reset();

    // Divider: strobes at clk 4,8,..,40, exact positions checked per tick.
    pulses = 0;
    for (int i = 2; i <= 40; i++) begin
      tick();
      if (ena_seen) pulses++;
    end
    chk("div_pulses", pulses, 10);

    n = 0;
    while (!fs_all && n < 1200) begin
      tick();
      n++;
    end
    chk("fs_done", fs_all, 1);

    // 0x0000 then 0x1000 forever; ramp then mute table.
    do_reset();
    feed_mode = 1; snd_in = 16'h0000; snd_valid = 1'b1;
    run_until_ena(31, 200, "t3_sync");
    for (int i = 0; i < 21; i++) begin
      mute = tbl[i].mute;
      wait_ena();
      chk("t3_tbl", pcm_out, tbl[i].pcm);
    end
    mute = 1'b0;

    // Reset while the strobe is high and output is non-zero.
    n = 0;
    while (!dac_ena && n < 8) begin
      tick();
      n++;
    end
    do_reset();

    // Starve after a single sample.
    feed_mode = 2; snd_in = 16'h1234; snd_valid = 1'b1; und_seen = 0;
    run_until_ena(64, 400, "t5");
    chk("t5_underruns", und_seen, 3);
    chk("t5_hold", pcm_out, 20'h12340);

    // Continuous incrementing stream.
    do_reset();
    feed_mode = 3; snd_in = 16'h0100; snd_valid = 1'b1;
    tick();
    tick();
    chk("t6_ready_full", snd_ready, 0);
    n = 0;
    while (ena_cnt < 96 && n < 600) begin
      if (dac_ena && ((ena_cnt + 1) % NPH == 0)) chk("t6_ready_at_pop", snd_ready, 0);
      tick();
      n++;
    end
    if (ena_cnt < 96) chk("t6_timeout", ena_cnt, 96);
    chk("t6_final", pcm_out, 20'h0D840);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
